// File: rtl/alu_mult_seq.sv
// Shift-add unsigned multiplier driving an external combinational ALU (one ADD/cycle); done n+1 edges after accept,
// start ignored while busy (no queuing). Define ZERO_BYPASS_EN to short-circuit zero operands straight to DONE.
module alu_mult_seq #(
    parameter int n  = 32,
    parameter int CW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] product,
    output logic [n-1:0]   alu_a,
    output logic [n-1:0]   alu_b,
    output logic [2:0]     alu_cmd,
    input  logic [n-1:0]   alu_result,
    input  logic           alu_carryout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   mcand_q, mcand_d;
    logic [n-1:0]   acc_q, acc_d;
    logic [n-1:0]   mreg_q, mreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*n-1:0] product_q, product_d;
    logic           done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mreg_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mreg_q    <= mreg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mreg_d    = mreg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    mreg_d  = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef ZERO_BYPASS_EN
                    if ((multiplicand == '0) || (multiplier == '0)) begin
                        mreg_d  = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                alu_a = acc_q;
                alu_b = mreg_q[0] ? mcand_q : '0;
                // Carry lands in the top bit so the (2n+1)-bit sum shifts right without loss.
                {acc_d, mreg_d} = {alu_carryout, alu_result, mreg_q[n-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = {acc_q, mreg_q};
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
    assign done    = done_q;
    assign product = product_q;
    assign alu_cmd = 3'd0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural combinational ADD ALU.
module tb_alu_mult_seq;

    localparam int N = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_cmd;
    logic [N-1:0]   alu_result;
    logic           alu_carryout;
    logic [N:0]     alu_sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_bad = 0;

    alu_mult_seq #(.n(N), .CW(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cmd      (alu_cmd),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout)
    );

    assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result   = alu_sum[N-1:0];
    assign alu_carryout = alu_sum[N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_cmd !== 3'd0) cmd_bad <= cmd_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one multiply; lat counts rising edges from the accepting edge to the edge where done is seen.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [63:0] exp_p, input int exp_lat);
        int lat;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_prod"}, product, exp_p);
    endtask

    initial begin
        int lat;
        int busy_low;
        int t_done [3];
        logic [N-1:0]  ha [3];
        logic [N-1:0]  hb [3];
        logic [63:0]   hp [3];

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", product, 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("m3x5", 32'd3, 32'd5, 64'd15, N + 1);
        do_op("mff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, N + 1);
`ifdef ZERO_BYPASS_EN
        do_op("mzero", 32'd0, 32'h12345678, 64'd0, 1);
`else
        do_op("mzero", 32'd0, 32'h12345678, 64'd0, N + 1);
`endif

        // Second request mid-run must be dropped.
        @(negedge clk);
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        busy_low = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (lat == 10) begin
                start        = 1'b1;
                multiplicand = 32'd2;
                multiplier   = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_low++;
        end
        check("ign_lat", 64'(lat), 64'(N + 1));
        check("ign_prod", product, 64'd63);
        check("ign_busy_gap", 64'(busy_low), 64'd0);
        @(posedge clk);
        #1;
        check("ign_no_restart", 64'(busy), 64'd0);

        // Reset in the middle of a run.
        @(negedge clk);
        multiplicand = 32'd100;
        multiplier   = 32'd200;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_prod", product, 64'd0);
        check("mid_rst_alu_a", 64'(alu_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("m6x7", 32'd6, 32'd7, 64'd42, N + 1);

        // start held high across three back-to-back operations.
        ha[0] = 32'd1;          hb[0] = 32'd1;     hp[0] = 64'd1;
        ha[1] = 32'h80000000;   hb[1] = 32'd2;     hp[1] = 64'h1_00000000;
        ha[2] = 32'd65535;      hb[2] = 32'd65536; hp[2] = 64'hFFFF_0000;
        @(negedge clk);
        multiplicand = ha[0];
        multiplier   = hb[0];
        start        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lat = 0;
            while (lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
                if (done) break;
            end
            t_done[i] = cyc;
            check($sformatf("hold%0d_done", i), 64'(done), 64'd1);
            check($sformatf("hold%0d_prod", i), product, hp[i]);
            @(negedge clk);
            if (i < 2) begin
                multiplicand = ha[i+1];
                multiplier   = hb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        check("hold_gap1", 64'(t_done[1] - t_done[0]), 64'(N + 2));
        check("hold_gap2", 64'(t_done[2] - t_done[1]), 64'(N + 2));

        check("alu_cmd_add", 64'(cmd_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
